// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the multicycle control unit:
//   state_t    - FSM state encoding
//   opclass_t  - decoded instruction class
//   OP_*       - 11-bit opcode patterns (Op = instruction bits [31:21])
//   ALUOP_*    - ALUOp encodings driven to the datapath
// ---------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_ADDR   = 4'd3,
      ST_MEM    = 4'd4,
      ST_EXEC   = 4'd5,
      ST_WB     = 4'd6,
      ST_BRANCH = 4'd7,
      ST_EXC    = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      OPC_LDUR    = 3'd0,
      OPC_STUR    = 3'd1,
      OPC_CBZ     = 3'd2,
      OPC_ADD     = 3'd3,
      OPC_SUB     = 3'd4,
      OPC_AND     = 3'd5,
      OPC_ORR     = 3'd6,
      OPC_INVALID = 3'd7
   } opclass_t;

   localparam logic [10:0] OP_LDUR    = 11'b11111000010;
   localparam logic [10:0] OP_STUR    = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;     // low 3 bits are don't-care
   localparam logic [10:0] OP_ADD     = 11'b10001011000;
   localparam logic [10:0] OP_SUB     = 11'b11001011000;
   localparam logic [10:0] OP_AND     = 11'b10001010000;
   localparam logic [10:0] OP_ORR     = 11'b10101010000;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_PASS = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   function automatic logic is_rtype(input opclass_t c);
      return (c == OPC_ADD) || (c == OPC_SUB) || (c == OPC_AND) || (c == OPC_ORR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_op_class.sv
// ---------------------------------------------------------------------------
// op_class
// Combinational map from the 11-bit opcode field to an instruction class.
// Ports:
//   i_op    [10:0]  instruction bits [31:21]
//   o_class         decoded class (OPC_INVALID for anything unrecognised)
// ---------------------------------------------------------------------------
module op_class
   import ctrl_pkg::*;
(
   input  logic [10:0] i_op,
   output opclass_t    o_class
);

   always_comb begin
      o_class = OPC_INVALID;
      if (i_op[10:3] == OP_CBZ_PFX) begin
         o_class = OPC_CBZ;
      end else begin
         case (i_op)
            OP_LDUR: o_class = OPC_LDUR;
            OP_STUR: o_class = OPC_STUR;
            OP_ADD:  o_class = OPC_ADD;
            OP_SUB:  o_class = OPC_SUB;
            OP_AND:  o_class = OPC_AND;
            OP_ORR:  o_class = OPC_ORR;
            default: o_class = OPC_INVALID;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore-style control FSM for a multicycle LEGv8-subset datapath. Outputs are
// decoded from the registered state plus the current opcode class; Zero and
// mem_ready only qualify strobes in the states that use them.
// Parameters:
//   MEM_TIMEOUT  cycles of mem_ready=0 tolerated in FETCH/MEM before trapping
// Ports:
//   clk, reset (async, active-high)
//   Op[10:0], Zero, mem_ready                         inputs
//   IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg,
//   RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]   datapath controls
//   Exc                                               sticky trap (until reset)
// Optional build macro MULTICYCLE_CTRL_PERF_EN adds retired[31:0] and
// cycles[31:0] performance counters.
// ---------------------------------------------------------------------------
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] Op,
   input  logic        Zero,
   input  logic        mem_ready,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        Reg2Loc,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        Branch,
   output logic [1:0]  ALUOp,
   output logic        Exc
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] retired,
   output logic [31:0] cycles
`endif
);

   localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_t      r_state;
   state_t      w_next;
   opclass_t    w_class;
   logic [CW-1:0] r_wait;
   logic [CW-1:0] w_wait_inc;
   logic        w_timeout;
   logic        w_in_mem_wait;

   op_class u_op_class (
      .i_op    (Op),
      .o_class (w_class)
   );

   assign w_in_mem_wait = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign w_wait_inc    = r_wait + CW'(1);
   // The cycle that would bring the count to MEM_TIMEOUT is the last one spent waiting.
   assign w_timeout     = w_in_mem_wait && !mem_ready && (w_wait_inc == CW'(MEM_TIMEOUT));

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   w_next = ST_FETCH;
         ST_FETCH: begin
            if (w_timeout)      w_next = ST_EXC;
            else if (mem_ready) w_next = ST_DECODE;
         end
         ST_DECODE: begin
            if ((w_class == OPC_LDUR) || (w_class == OPC_STUR)) w_next = ST_ADDR;
            else if (is_rtype(w_class))                        w_next = ST_EXEC;
            else if (w_class == OPC_CBZ)                       w_next = ST_BRANCH;
            else                                               w_next = ST_EXC;
         end
         ST_ADDR:   w_next = ST_MEM;
         ST_MEM: begin
            if (w_timeout)      w_next = ST_EXC;
            else if (mem_ready) w_next = (w_class == OPC_LDUR) ? ST_WB : ST_FETCH;
         end
         ST_EXEC:   w_next = ST_WB;
         ST_WB:     w_next = ST_FETCH;
         ST_BRANCH: w_next = ST_FETCH;
         ST_EXC:    w_next = ST_EXC;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         // Any state change clears the count, which covers entry into FETCH and MEM.
         if (r_state != w_next)
            r_wait <= '0;
         else if (w_in_mem_wait && !mem_ready)
            r_wait <= w_wait_inc;
      end
   end

   always_comb begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      Reg2Loc  = 1'b0;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Branch   = 1'b0;
      ALUOp    = ALUOP_ADD;
      Exc      = 1'b0;
      case (r_state)
         ST_FETCH: begin
            MemRead = 1'b1;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         ST_DECODE: Reg2Loc = (w_class == OPC_STUR) || (w_class == OPC_CBZ);
         ST_ADDR: begin
            ALUSrc = 1'b1;
            ALUOp  = ALUOP_ADD;
         end
         ST_MEM: begin
            MemRead  = (w_class == OPC_LDUR);
            MemWrite = (w_class == OPC_STUR);
         end
         ST_EXEC:   ALUOp = ALUOP_FUNC;
         ST_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (w_class == OPC_LDUR);
         end
         ST_BRANCH: begin
            Reg2Loc = 1'b1;
            ALUOp   = ALUOP_PASS;
            PCWrite = Zero;
            Branch  = Zero;
         end
         ST_EXC:    Exc = 1'b1;
         default: ;
      endcase
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] r_cycles;
   logic [31:0] r_retired;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycles  <= '0;
         r_retired <= '0;
      end else begin
         r_cycles <= r_cycles + 32'd1;
         if ((w_next == ST_FETCH) &&
             ((r_state == ST_WB) || (r_state == ST_MEM) || (r_state == ST_BRANCH)))
            r_retired <= r_retired + 32'd1;
      end
   end

   assign cycles  = r_cycles;
   assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed-vector bench for multicycle_ctrl. Each vector drives Op/Zero/
// mem_ready after the falling edge and compares the 12-bit control bundle
// {IRWrite,PCWrite,Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,
//  ALUOp[1:0],Exc} with a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

   // Hand-computed control bundles
   localparam logic [11:0] X_ZERO   = 12'h000;
   localparam logic [11:0] X_FWAIT  = 12'h020; // MemRead
   localparam logic [11:0] X_FRDY   = 12'hC20; // IRWrite|PCWrite|MemRead
   localparam logic [11:0] X_DEC_S  = 12'h200; // Reg2Loc
   localparam logic [11:0] X_ADDR   = 12'h100; // ALUSrc, ALUOp=00
   localparam logic [11:0] X_MEM_LD = 12'h020; // MemRead
   localparam logic [11:0] X_MEM_ST = 12'h010; // MemWrite
   localparam logic [11:0] X_EXEC   = 12'h004; // ALUOp=10
   localparam logic [11:0] X_WB_R   = 12'h040; // RegWrite
   localparam logic [11:0] X_WB_LD  = 12'h0C0; // RegWrite|MemtoReg
   localparam logic [11:0] X_BR_T   = 12'h60A; // Reg2Loc|PCWrite|Branch|ALUOp=01
   localparam logic [11:0] X_BR_N   = 12'h202; // Reg2Loc|ALUOp=01
   localparam logic [11:0] X_EXC    = 12'h001; // Exc

   localparam logic [10:0] C_ADD  = 11'h458;
   localparam logic [10:0] C_SUB  = 11'h658;
   localparam logic [10:0] C_ORR  = 11'h550;
   localparam logic [10:0] C_LDUR = 11'h7C2;
   localparam logic [10:0] C_STUR = 11'h7C0;
   localparam logic [10:0] C_CBZ  = 11'h5A0;
   localparam logic [10:0] C_CBZ7 = 11'h5A7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] Op = '0;
   logic        Zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
   logic        MemRead, MemWrite, Branch, Exc;
   logic [1:0]  ALUOp;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] retired, cycles;
`endif
   logic [11:0] w_outs;

   int n_vec = 0;
   int n_err = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .Op        (Op),
      .Zero      (Zero),
      .mem_ready (mem_ready),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .Reg2Loc   (Reg2Loc),
      .ALUSrc    (ALUSrc),
      .MemtoReg  (MemtoReg),
      .RegWrite  (RegWrite),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Branch    (Branch),
      .ALUOp     (ALUOp),
      .Exc       (Exc)
`ifdef MULTICYCLE_CTRL_PERF_EN
      ,
      .retired   (retired),
      .cycles    (cycles)
`endif
   );

   always #5 clk = ~clk;

   assign w_outs = {IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                    MemRead, MemWrite, Branch, ALUOp, Exc};

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %03h expected %03h", tag, got, exp);
      end
   endtask

   // One state cycle: drive inputs after the falling edge, check 1 time unit later.
   task automatic cyc(input logic [10:0] op, input logic z, input logic rdy,
                      input logic [11:0] exp, input string tag);
      @(negedge clk);
      Op = op;
      Zero = z;
      mem_ready = rdy;
      #1;
      chk(tag, w_outs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_outs", w_outs, X_ZERO);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("idle", w_outs, X_ZERO);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_init", w_outs, X_ZERO);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("idle", w_outs, X_ZERO);

      // ADD: FETCH, DECODE, EXEC, WB (mem_ready low outside FETCH is ignored)
      cyc(C_ADD, 1'b0, 1'b1, X_FRDY, "add_fetch");
      cyc(C_ADD, 1'b0, 1'b0, X_ZERO, "add_dec");
      cyc(C_ADD, 1'b0, 1'b0, X_EXEC, "add_exec");
      cyc(C_ADD, 1'b0, 1'b0, X_WB_R, "add_wb");

      // ORR: 14 waiting FETCH cycles is one short of the trap
      for (int i = 0; i < 14; i++) cyc(C_ORR, 1'b0, 1'b0, X_FWAIT, "orr_fwait");
      cyc(C_ORR, 1'b0, 1'b1, X_FRDY, "orr_fetch");
      cyc(C_ORR, 1'b0, 1'b1, X_ZERO, "orr_dec");
      cyc(C_ORR, 1'b0, 1'b1, X_EXEC, "orr_exec");
      cyc(C_ORR, 1'b0, 1'b1, X_WB_R, "orr_wb");

      // SUB
      cyc(C_SUB, 1'b0, 1'b1, X_FRDY, "sub_fetch");
      cyc(C_SUB, 1'b0, 1'b0, X_ZERO, "sub_dec");
      cyc(C_SUB, 1'b0, 1'b0, X_EXEC, "sub_exec");
      cyc(C_SUB, 1'b0, 1'b0, X_WB_R, "sub_wb");

      // LDUR with three MEM wait cycles
      cyc(C_LDUR, 1'b0, 1'b1, X_FRDY, "ld_fetch");
      cyc(C_LDUR, 1'b0, 1'b0, X_ZERO, "ld_dec");
      cyc(C_LDUR, 1'b0, 1'b0, X_ADDR, "ld_addr");
      for (int i = 0; i < 3; i++) cyc(C_LDUR, 1'b0, 1'b0, X_MEM_LD, "ld_mwait");
      cyc(C_LDUR, 1'b0, 1'b1, X_MEM_LD, "ld_mrdy");
      cyc(C_LDUR, 1'b0, 1'b0, X_WB_LD, "ld_wb");

      // STUR, no wait
      cyc(C_STUR, 1'b0, 1'b1, X_FRDY, "st_fetch");
      cyc(C_STUR, 1'b0, 1'b0, X_DEC_S, "st_dec");
      cyc(C_STUR, 1'b0, 1'b0, X_ADDR, "st_addr");
      cyc(C_STUR, 1'b0, 1'b1, X_MEM_ST, "st_mem");

      // CBZ taken, then not taken (don't-care low bits)
      cyc(C_CBZ, 1'b1, 1'b1, X_FRDY, "cbz_fetch");
      cyc(C_CBZ, 1'b1, 1'b0, X_DEC_S, "cbz_dec");
      cyc(C_CBZ, 1'b1, 1'b0, X_BR_T, "cbz_taken");
      cyc(C_CBZ7, 1'b0, 1'b1, X_FRDY, "cbz7_fetch");
      cyc(C_CBZ7, 1'b0, 1'b0, X_DEC_S, "cbz7_dec");
      cyc(C_CBZ7, 1'b0, 1'b0, X_BR_N, "cbz7_nottaken");

      // STUR interrupted by reset in the middle of a MEM wait
      cyc(C_STUR, 1'b0, 1'b1, X_FRDY, "st2_fetch");
      cyc(C_STUR, 1'b0, 1'b0, X_DEC_S, "st2_dec");
      cyc(C_STUR, 1'b0, 1'b0, X_ADDR, "st2_addr");
      cyc(C_STUR, 1'b0, 1'b0, X_MEM_ST, "st2_mem");
      #1;
      reset = 1'b1;
      #1;
      chk("st2_rst_async", w_outs, X_ZERO);
      @(negedge clk);
      #1;
      chk("st2_rst_hold", w_outs, X_ZERO);
      reset = 1'b0;
      #1;
      chk("st2_rst_idle", w_outs, X_ZERO);

      // FETCH timeout: 15 waiting cycles, then EXC; IRWrite never rises
      for (int i = 0; i < 15; i++) cyc(C_ADD, 1'b0, 1'b0, X_FWAIT, "fto_wait");
      cyc(C_ADD, 1'b0, 1'b1, X_EXC, "fto_exc");
      cyc(C_ADD, 1'b1, 1'b1, X_EXC, "fto_exc_hold");

      // Invalid opcode traps after DECODE and stays trapped
      do_reset();
      cyc(11'h000, 1'b0, 1'b1, X_FRDY, "inv_fetch");
      cyc(11'h000, 1'b0, 1'b0, X_ZERO, "inv_dec");
      for (int i = 0; i < 20; i++)
         cyc(11'h000, i[0], i[1], X_EXC, "inv_exc");

      // MEM timeout on LDUR
      do_reset();
      cyc(C_LDUR, 1'b0, 1'b1, X_FRDY, "mto_fetch");
      cyc(C_LDUR, 1'b0, 1'b0, X_ZERO, "mto_dec");
      cyc(C_LDUR, 1'b0, 1'b0, X_ADDR, "mto_addr");
      for (int i = 0; i < 15; i++) cyc(C_LDUR, 1'b0, 1'b0, X_MEM_LD, "mto_wait");
      cyc(C_LDUR, 1'b0, 1'b0, X_EXC, "mto_exc");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
